// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//
// Upstream feeder for the APB memory-controller slave. Simple valid/ready
// read/write requests are buffered in a small FIFO and issued in order as APB
// SETUP/ACCESS transfers. Each completed transfer produces a one-cycle response
// pulse, with read data for reads.
//
// Optional feature macro: APB_MASTER_PREADY_EN
//   defined   : adds input pready. ACCESS is held while pready=0, and reads
//               sample prdata in ACCESS itself (CAPTURE is never entered).
//   undefined : no pready port; slave assumed zero-wait. Read data arrives from
//               the registered slave one cycle after ACCESS (CAPTURE state).
//
// Ports
//   clk        in   1           clock, all logic on posedge
//   rst_n      in   1           asynchronous active-low reset
//   req_valid  in   1           request present
//   req_ready  out  1           FIFO not full; transfer when valid&ready
//   req_addr   in   ADDR_WIDTH  request address
//   req_wdata  in   DATA_WIDTH  write data (ignored for reads)
//   req_write  in   1           1=write, 0=read
//   rsp_valid  out  1           one-cycle pulse: transfer completed
//   rsp_write  out  1           kind of completed transfer
//   rsp_rdata  out  DATA_WIDTH  read data; held until next read response
//   busy       out  1           FIFO non-empty or FSM not IDLE
//   paddr      out  ADDR_WIDTH  APB address
//   pwdata     out  DATA_WIDTH  APB write data
//   pwrite     out  1           APB direction
//   psel       out  1           APB select
//   penable    out  1           APB enable
//   prdata     in   DATA_WIDTH  APB read data from slave
//   pready     in   1           APB ready (APB_MASTER_PREADY_EN only)
// -----------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_write,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pwrite,
  output logic                  psel,
  output logic                  penable,
  input  logic [DATA_WIDTH-1:0] prdata
`ifdef APB_MASTER_PREADY_EN
  ,
  input  logic                  pready
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] fifo_addr_q  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_wdata_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_write_q;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);

  // Ready comes from the registered count only, so a pop in a full cycle does
  // not open the slot until the following cycle.
  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth: pointers wrap by natural overflow.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q]  <= req_addr;
      fifo_wdata_q[wr_ptr_q] <= req_wdata;
      fifo_write_q[wr_ptr_q] <= req_write;
    end
  end

  // ---------------------------------------------------------------------------
  // APB transfer FSM
  // ---------------------------------------------------------------------------
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    pop         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          paddr_d   = fifo_addr_q[rd_ptr_q];
          pwdata_d  = fifo_wdata_q[rd_ptr_q];
          pwrite_d  = fifo_write_q[rd_ptr_q];
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
`ifdef APB_MASTER_PREADY_EN
        // Wait states: hold psel/penable and the address phase until pready.
        if (pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = pwrite_q;
          if (!pwrite_q) rsp_rdata_d = prdata;
          state_d     = ST_IDLE;
        end
`else
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (pwrite_q) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          // The slave registers its read data, so it is only visible next cycle.
          state_d = ST_CAPTURE;
        end
`endif
      end

      ST_CAPTURE: begin
        rsp_rdata_d = prdata;
        rsp_valid_d = 1'b1;
        rsp_write_d = 1'b0;
        state_d     = ST_IDLE;
      end

      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pwrite    = pwrite_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = !fifo_empty || (state_q != ST_IDLE);

endmodule
